mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative 20-bit multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read-data operands and produces a 40-bit result in HI/LO holding registers.
- Writeback moves HI/LO into the register file.
- Multi-cycle with a start/busy/done handshake, so the pipeline stalls on busy rather than widening the ALU.

Parameters:
- WIDTH, 20, operand and HI/LO width; the design is verified only at 20.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when accepting (IDLE or DONE).
- op  input  1  0 = MULT, 1 = DIV.
- signed_op  input  1  signed operation request; used only when MD_SIGNED_EN is defined.
- flush  input  1  synchronous abort of an in-flight operation.
- operand_a  input  WIDTH  multiplicand or dividend (register read data 1).
- operand_b  input  WIDTH  multiplier or divisor (register read data 2).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  valid while done is high.
- hi  output  WIDTH  MULT: product[39:20]; DIV: remainder.
- lo  output  WIDTH  MULT: product[19:0]; DIV: quotient.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0, done = 0, div_by_zero = 0; hi = lo = 0; counter = 0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start = 1 at edge E0:
  - Operands and op are latched and the counter is cleared.
  - DIV with operand_b == 0 goes to DONE at E0 and completes immediately (see below).
  - Otherwise the state goes to RUN.
- RUN:
  - One iteration per edge, E1..E20: shift-add for MULT, restoring shift-subtract for DIV.
  - At E20 the result is written into hi/lo and the state goes to DONE.
- DONE: lasts one cycle (done = 1, busy = 0). Next edge goes to IDLE, or back to RUN/DONE if start = 1 (back-to-back operations allowed).
- Latency: done is high in the cycle after E20, i.e. 21 cycles after start is sampled.
- Divide by zero: done in the cycle after E0; hi = dividend, lo = 20'hFFFFF, div_by_zero = 1.
- hi/lo update only on completion and hold otherwise, so writeback may read them at any time.
- start during RUN is ignored; no queueing.
- flush = 1 in any state forces IDLE at the next edge.
  - hi/lo keep their previous values; no done pulse.
  - flush has priority over start and over completion at E20.
- Unsigned arithmetic:
  - Product is exactly 40 bits, so there is no overflow.
  - Quotient = floor(a/b); remainder = a − q·b.

Optional Feature:
- MD_SIGNED_EN defined:
  - When signed_op = 1, operands are converted to magnitudes and the unsigned core runs.
  - Product sign = sign_a XOR sign_b. Quotient sign = sign_a XOR sign_b. Remainder takes the sign of the dividend.
  - 20'h80000 / 20'hFFFFF gives lo = 20'h80000 and hi = 0 (wraps).
  - Latency is unchanged.
- MD_SIGNED_EN undefined: signed_op is ignored and all operations are unsigned; no sign logic is synthesised.

Decomposition:
- Shared package md_pkg:
  - MD_WIDTH = 20.
  - Op encodings MD_OP_MULT = 1'b0 and MD_OP_DIV = 1'b1.
  - State enum md_state_t {IDLE, RUN, DONE}.
  - Divide-by-zero quotient constant MD_DBZ_Q = 20'hFFFFF.
- Sub-module md_sign_adjust: operand magnitude conversion and result negation. Instantiated only under MD_SIGNED_EN.
- The iteration datapath stays in the top module.

Test Plan:
- MULT 12×6 (a = 20'd12, b = 20'd6) → done 21 cycles after start; hi = 0, lo = 20'd72; busy high for exactly 20 cycles.
- MULT 20'hFFFFF×20'hFFFFF → hi = 20'hFFFFE, lo = 20'h00001; then DIV 15/4 back-to-back from DONE → lo = 3, hi = 3.
- DIV 9/0 → done one cycle after start; div_by_zero = 1, hi = 9, lo = 20'hFFFFF. Next op has div_by_zero = 0.
- Start MULT 3×3, pulse start with other operands at cycle 5 (ignored), then assert flush at cycle 10 → IDLE, no done, hi/lo unchanged; a fresh MULT 8×5 → lo = 40.
- Deassert rst_n at cycle 7 of a DIV → busy, done, hi and lo go to 0 immediately (asynchronous); after release, MULT 4×3 → lo = 12.
- With MD_SIGNED_EN, signed MULT 20'hFFFF4 (−12) × 5 → hi = 20'hFFFFF, lo = 20'hFFFC4. Signed DIV −15/4 → lo = 20'hFFFFD, hi = 20'hFFFFD.
- Without MD_SIGNED_EN, the same MULT gives the unsigned product: hi = 20'h00004, lo = 20'hFFFC4.

Source files
------------

// File: rtl/md_pkg.sv
// ============================================================================
// Module      : md_pkg
// Description : Shared constants, op encodings and FSM state type for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam int MD_WIDTH = 20;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    localparam logic [MD_WIDTH-1:0] MD_DBZ_Q = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/md_sign_adjust.sv
// ============================================================================
// Module      : md_sign_adjust
// Description : Signed-operation support: operand magnitude conversion and
//               sign restoration of the unsigned core result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sign_adjust
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             i_signed_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_mag_a,
    output logic [WIDTH-1:0] o_mag_b,
    output logic             o_sign_a,
    output logic             o_sign_b,
    input  logic             i_res_op,
    input  logic             i_res_sign_a,
    input  logic             i_res_sign_b,
    input  logic [WIDTH-1:0] i_raw_hi,
    input  logic [WIDTH-1:0] i_raw_lo,
    output logic [WIDTH-1:0] o_adj_hi,
    output logic [WIDTH-1:0] o_adj_lo
);

    logic [2*WIDTH-1:0] w_prod_neg;
    logic               w_neg_res;

    assign o_sign_a = i_signed_op & i_a[WIDTH-1];
    assign o_sign_b = i_signed_op & i_b[WIDTH-1];
    assign o_mag_a  = o_sign_a ? (~i_a + 1'b1) : i_a;
    assign o_mag_b  = o_sign_b ? (~i_b + 1'b1) : i_b;

    assign w_prod_neg = ~{i_raw_hi, i_raw_lo} + 1'b1;
    assign w_neg_res  = i_res_sign_a ^ i_res_sign_b;

    // Remainder follows the dividend sign; the most-negative quotient wraps.
    always_comb begin
        o_adj_hi = i_raw_hi;
        o_adj_lo = i_raw_lo;
        if (i_res_op == MD_OP_MULT) begin
            if (w_neg_res) begin
                {o_adj_hi, o_adj_lo} = w_prod_neg;
            end
        end else begin
            if (w_neg_res) begin
                o_adj_lo = ~i_raw_lo + 1'b1;
            end
            if (i_res_sign_a) begin
                o_adj_hi = ~i_raw_hi + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 20-bit shift-add multiplier / restoring divider with
//               start/busy/done handshake and HI/LO result registers.
//               Signed support is built only when MD_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_wh;
    logic [WIDTH-1:0] r_wl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_wh;
    logic [WIDTH-1:0] w_nxt_wl;
    logic             w_last;

`ifdef MD_SIGNED_EN
    logic r_sa;
    logic r_sb;
    logic w_sa;
    logic w_sb;

    md_sign_adjust #(
        .WIDTH(WIDTH)
    ) u_sign_adjust (
        .i_signed_op (signed_op),
        .i_a         (operand_a),
        .i_b         (operand_b),
        .o_mag_a     (w_mag_a),
        .o_mag_b     (w_mag_b),
        .o_sign_a    (w_sa),
        .o_sign_b    (w_sb),
        .i_res_op    (r_op),
        .i_res_sign_a(r_sa),
        .i_res_sign_b(r_sb),
        .i_raw_hi    (w_nxt_wh),
        .i_raw_lo    (w_nxt_wl),
        .o_adj_hi    (w_res_hi),
        .o_adj_lo    (w_res_lo)
    );
`else
    logic w_unused_signed_op;

    assign w_unused_signed_op = signed_op;
    assign w_mag_a  = operand_a;
    assign w_mag_b  = operand_b;
    assign w_res_hi = w_nxt_wh;
    assign w_res_lo = w_nxt_wl;
`endif

    // MULT: {r_wh,r_wl} is the partial product, multiplier consumed from r_wl[0].
    assign w_sum   = {1'b0, r_wh} + {1'b0, (r_wl[0] ? r_b : {WIDTH{1'b0}})};
    // DIV: r_wh is the partial remainder, dividend bits shift out of r_wl.
    assign w_shift = {r_wh, r_wl[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_diff[WIDTH];

    always_comb begin
        if (r_op == MD_OP_MULT) begin
            w_nxt_wh = w_sum[WIDTH:1];
            w_nxt_wl = {w_sum[0], r_wl[WIDTH-1:1]};
        end else begin
            w_nxt_wh = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_nxt_wl = {r_wl[WIDTH-2:0], w_ge};
        end
    end

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= MD_OP_MULT;
            r_b     <= '0;
            r_wh    <= '0;
            r_wl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
`ifdef MD_SIGNED_EN
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_op  <= op;
                            r_cnt <= '0;
                            r_wh  <= '0;
                            r_wl  <= (op == MD_OP_MULT) ? w_mag_b : w_mag_a;
                            r_b   <= (op == MD_OP_MULT) ? w_mag_a : w_mag_b;
`ifdef MD_SIGNED_EN
                            r_sa  <= w_sa;
                            r_sb  <= w_sb;
`endif
                            if (op == MD_OP_DIV && operand_b == '0) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_dbz   <= 1'b1;
                                r_hi    <= operand_a;
                                r_lo    <= MD_DBZ_Q;
                            end else begin
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    RUN: begin
                        r_wh  <= w_nxt_wh;
                        r_wl  <= w_nxt_wl;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit: directed cases plus
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         signed_op = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(
        .WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .signed_op  (signed_op),
        .flush      (flush),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic o, input logic s, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] eh,
                         output logic [W-1:0] el, output logic ed);
        longint lx, ly, r;
        logic   sg;
`ifdef MD_SIGNED_EN
        sg = s;
`else
        sg = s & 1'b0;
`endif
        lx = sg ? longint'($signed(x)) : longint'(x);
        ly = sg ? longint'($signed(y)) : longint'(y);
        ed = 1'b0;
        if (o == MD_OP_DIV && y == '0) begin
            eh = x;
            el = 20'hFFFFF;
            ed = 1'b1;
        end else if (o == MD_OP_MULT) begin
            r  = lx * ly;
            eh = r[39:20];
            el = r[19:0];
        end else begin
            r  = lx % ly;
            eh = r[19:0];
            r  = lx / ly;
            el = r[19:0];
        end
    endtask

    // Issues one operation (from IDLE or DONE) and checks it to completion.
    task automatic run_op(input string tag, input logic o, input logic s,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eh, el, ph, pl;
        logic         ed, hold_ok;
        int           lat, bcnt;
        model(o, s, x, y, eh, el, ed);
        ph = hi;
        pl = lo;
        op = o; signed_op = s; operand_a = x; operand_b = y; start = 1'b1;
        tick();
        start = 1'b0;
        operand_a = W'($urandom);
        operand_b = W'($urandom);
        lat = 1; bcnt = 0; hold_ok = 1'b1;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (hi !== ph || lo !== pl) hold_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, ".latency"}, 40'(lat), ed ? 40'd1 : 40'd21);
        check({tag, ".busy_cycles"}, 40'(bcnt), ed ? 40'd0 : 40'd20);
        check({tag, ".hold"}, 40'(hold_ok), 40'd1);
        check({tag, ".hi"}, 40'(hi), 40'(eh));
        check({tag, ".lo"}, 40'(lo), 40'(el));
        check({tag, ".dbz"}, 40'(div_by_zero), 40'(ed));
    endtask

    initial begin
        logic [W-1:0] ph, pl;
        logic         seen_done;

        #12;
        check("reset.busy", 40'(busy), 40'd0);
        check("reset.done", 40'(done), 40'd0);
        check("reset.dbz", 40'(div_by_zero), 40'd0);
        check("reset.hi", 40'(hi), 40'd0);
        check("reset.lo", 40'(lo), 40'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul_12x6", MD_OP_MULT, 1'b0, 20'd12, 20'd6);
        check("mul_12x6.lo_const", 40'(lo), 40'd72);
        tick();
        check("done_one_cycle", 40'(done), 40'd0);

        run_op("mul_max", MD_OP_MULT, 1'b0, 20'hFFFFF, 20'hFFFFF);
        check("mul_max.hi_const", 40'(hi), 40'h00000FFFFE);
        run_op("div_15_4_b2b", MD_OP_DIV, 1'b0, 20'd15, 20'd4);
        check("div_15_4.lo_const", 40'(lo), 40'd3);
        tick();

        run_op("div_9_0", MD_OP_DIV, 1'b0, 20'd9, 20'd0);
        run_op("after_dbz", MD_OP_DIV, 1'b0, 20'd100, 20'd7);
        tick();

        // Flush mid-operation, with an ignored start during RUN.
        ph = hi; pl = lo;
        op = MD_OP_MULT; operand_a = 20'd3; operand_b = 20'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; operand_a = 20'd7; operand_b = 20'd9;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("flush.busy_before", 40'(busy), 40'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.busy", 40'(busy), 40'd0);
        check("flush.done", 40'(done), 40'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) seen_done = 1'b1;
            tick();
        end
        check("flush.no_done", 40'(seen_done), 40'd0);
        check("flush.hi_hold", 40'(hi), 40'(ph));
        check("flush.lo_hold", 40'(lo), 40'(pl));
        run_op("mul_8x5", MD_OP_MULT, 1'b0, 20'd8, 20'd5);
        tick();

        // Asynchronous reset in the middle of a DIV.
        op = MD_OP_DIV; operand_a = 20'd1000; operand_b = 20'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", 40'(busy), 40'd0);
        check("arst.done", 40'(done), 40'd0);
        check("arst.hi", 40'(hi), 40'd0);
        check("arst.lo", 40'(lo), 40'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("mul_4x3", MD_OP_MULT, 1'b0, 20'd4, 20'd3);
        tick();

        run_op("smul_m12x5", MD_OP_MULT, 1'b1, 20'hFFFF4, 20'd5);
`ifdef MD_SIGNED_EN
        check("smul.hi_const", 40'(hi), 40'h00000FFFFF);
        run_op("sdiv_m15_4", MD_OP_DIV, 1'b1, 20'hFFFF1, 20'd4);
        check("sdiv.lo_const", 40'(lo), 40'h00000FFFFD);
        run_op("sdiv_wrap", MD_OP_DIV, 1'b1, 20'h80000, 20'hFFFFF);
`else
        check("umul.hi_const", 40'(hi), 40'h0000000004);
`endif
        tick();

        for (int i = 0; i < 40; i++) begin
            logic         ro, rs;
            logic [W-1:0] rx, ry;
            ro = 1'($urandom);
            rs = 1'($urandom);
            rx = W'($urandom);
            case ($urandom_range(0, 5))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       ry = 20'hFFFFF;
                default: ry = W'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), ro, rs, rx, ry);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
